// File: rtl/shift_sequencer.sv
// Multi-cycle controller for the shared 32-bit barrel shifter. Long shifts are
// split into chunks of at most MAX_STEP so that the shifter's critical path stays short.
module shift_sequencer #(
  parameter int MAX_STEP = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [31:0] in,
  input  logic [31:0] shamt,
  input  logic        dir,
  input  logic        arith_or_logic,
  output logic        busy,
  output logic        done,
  output logic [31:0] out,
  output logic [31:0] sh_in,
  output logic [31:0] sh_shamt,
  output logic        sh_dir,
  output logic        sh_arith,
  input  logic [31:0] sh_out
);

  localparam logic [4:0] STEP_MAX = 5'(MAX_STEP);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_next;
  logic [31:0] r_acc;
  logic [4:0]  r_rem;
  logic        r_dir;
  logic        r_arith;
  logic [31:0] r_out;
  logic [4:0]  w_step;
  logic [4:0]  w_rem_next;
  logic        w_unused_shamt_hi;

  assign w_unused_shamt_hi = ^shamt[31:5];

  assign w_step     = (r_rem > STEP_MAX) ? STEP_MAX : r_rem;
  assign w_rem_next = r_rem - w_step;

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (start) w_next = (shamt[4:0] != 5'd0) ? S_SHIFT : S_DONE;
      S_SHIFT: if (w_rem_next == 5'd0) w_next = S_DONE;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_acc   <= '0;
      r_rem   <= '0;
      r_dir   <= 1'b0;
      r_arith <= 1'b0;
      r_out   <= '0;
    end else begin
      r_state <= w_next;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_acc   <= in;
            r_rem   <= shamt[4:0];
            r_dir   <= dir;
            r_arith <= arith_or_logic;
            // A zero-length shift completes immediately with the operand itself.
            if (shamt[4:0] == 5'd0) r_out <= in;
          end
        end
        S_SHIFT: begin
          r_acc <= sh_out;
          r_rem <= w_rem_next;
          if (w_rem_next == 5'd0) r_out <= sh_out;
        end
        default: ;
      endcase
    end
  end

  assign busy     = (r_state != S_IDLE);
  assign done     = (r_state == S_DONE);
  assign out      = r_out;
  assign sh_in    = r_acc;
  assign sh_shamt = (r_state == S_SHIFT) ? {27'b0, w_step} : 32'd0;
  assign sh_dir   = r_dir;
  assign sh_arith = r_arith;

endmodule

// File: tb/tb_shift_sequencer.sv
// Directed bench for shift_sequencer with a behavioural barrel shifter attached
// to the shifter ports; expected values are hand-computed.
module tb_shift_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [31:0] in;
  logic [31:0] shamt;
  logic        dir;
  logic        arith_or_logic;
  logic        busy;
  logic        done;
  logic [31:0] out;
  logic [31:0] sh_in;
  logic [31:0] sh_shamt;
  logic        sh_dir;
  logic        sh_arith;
  logic [31:0] sh_out;

  int total = 0;
  int bad   = 0;

  shift_sequencer #(.MAX_STEP(8)) dut (
    .clk(clk), .rst(rst), .start(start), .in(in), .shamt(shamt), .dir(dir),
    .arith_or_logic(arith_or_logic), .busy(busy), .done(done), .out(out),
    .sh_in(sh_in), .sh_shamt(sh_shamt), .sh_dir(sh_dir), .sh_arith(sh_arith),
    .sh_out(sh_out)
  );

  always #5 clk = ~clk;

  // The external combinational shifter
  always_comb begin
    if (!sh_dir)      sh_out = sh_in << sh_shamt[4:0];
    else if (sh_arith) sh_out = 32'($signed(sh_in) >>> sh_shamt[4:0]);
    else              sh_out = sh_in >> sh_shamt[4:0];
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic req(input logic [31:0] a, input logic [31:0] n, input logic d, input logic ar);
    in = a; shamt = n; dir = d; arith_or_logic = ar; start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; in = '0; shamt = '0; dir = 1'b0; arith_or_logic = 1'b0;
    #2;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_out", out, 32'd0);
    chk("rst_sh_in", sh_in, 32'd0);
    chk("rst_sh_shamt", sh_shamt, 32'd0);
    tick(); tick();
    rst = 1'b0;
    tick();
    chk("idle_busy", 32'(busy), 32'd0);

    // Short left shift: 1234 << 4
    req(32'd1234, 32'd4, 1'b0, 1'b0);
    chk("t1_c1_busy", 32'(busy), 32'd1);
    chk("t1_c1_done", 32'(done), 32'd0);
    chk("t1_c1_shamt", sh_shamt, 32'd4);
    chk("t1_c1_sh_in", sh_in, 32'd1234);
    tick();
    chk("t1_c2_done", 32'(done), 32'd1);
    chk("t1_c2_busy", 32'(busy), 32'd1);
    chk("t1_c2_out", out, 32'd19744);
    chk("t1_c2_shamt", sh_shamt, 32'd0);
    tick();
    chk("t1_c3_done", 32'(done), 32'd0);
    chk("t1_c3_busy", 32'(busy), 32'd0);
    chk("t1_c3_out", out, 32'd19744);

    // Multi-step arithmetic right with an ignored start in cycle 1
    req(32'h8000_0000, 32'd20, 1'b1, 1'b1);
    chk("t2_c1_shamt", sh_shamt, 32'd8);
    chk("t2_c1_sh_dir", 32'(sh_dir), 32'd1);
    chk("t2_c1_sh_arith", 32'(sh_arith), 32'd1);
    in = 32'd7; shamt = 32'd1; dir = 1'b0; arith_or_logic = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    chk("t2_c2_shamt", sh_shamt, 32'd8);
    chk("t2_c2_sh_in", sh_in, 32'hFF80_0000);
    chk("t2_c2_sh_dir", 32'(sh_dir), 32'd1);
    tick();
    chk("t2_c3_shamt", sh_shamt, 32'd4);
    chk("t2_c3_done", 32'(done), 32'd0);
    tick();
    chk("t2_c4_done", 32'(done), 32'd1);
    chk("t2_c4_out", out, 32'hFFFF_F800);
    tick();
    chk("t2_c5_done", 32'(done), 32'd0);
    chk("t2_c5_busy", 32'(busy), 32'd0);
    chk("t2_c5_out", out, 32'hFFFF_F800);

    // Multi-step logical right
    req(32'h8000_0000, 32'd20, 1'b1, 1'b0);
    chk("t3_c1_shamt", sh_shamt, 32'd8);
    tick();
    chk("t3_c2_shamt", sh_shamt, 32'd8);
    tick();
    chk("t3_c3_shamt", sh_shamt, 32'd4);
    tick();
    chk("t3_c4_done", 32'(done), 32'd1);
    chk("t3_c4_out", out, 32'h0000_0800);
    tick();

    // Maximum shift: 1 << 31 in steps 8,8,8,7
    req(32'd1, 32'd31, 1'b0, 1'b0);
    chk("t4_c1_shamt", sh_shamt, 32'd8);
    tick();
    chk("t4_c2_shamt", sh_shamt, 32'd8);
    tick();
    chk("t4_c3_shamt", sh_shamt, 32'd8);
    tick();
    chk("t4_c4_shamt", sh_shamt, 32'd7);
    chk("t4_c4_done", 32'(done), 32'd0);
    tick();
    chk("t4_c5_done", 32'(done), 32'd1);
    chk("t4_c5_out", out, 32'h8000_0000);
    tick();

    // Zero-amount shifts (shamt=0 and shamt=32)
    req(32'h1234_ABCD, 32'd0, 1'b0, 1'b0);
    chk("t5a_c1_done", 32'(done), 32'd1);
    chk("t5a_c1_out", out, 32'h1234_ABCD);
    chk("t5a_c1_shamt", sh_shamt, 32'd0);
    tick();
    chk("t5a_c2_done", 32'(done), 32'd0);
    req(32'd99, 32'd3, 1'b0, 1'b0);
    tick(); tick();
    chk("t5b_pre_out", out, 32'd792);
    req(32'h1234_ABCD, 32'd32, 1'b1, 1'b1);
    chk("t5b_c1_done", 32'(done), 32'd1);
    chk("t5b_c1_out", out, 32'h1234_ABCD);
    chk("t5b_c1_shamt", sh_shamt, 32'd0);
    tick();

    // Reset during the second SHIFT cycle
    req(32'h8000_0000, 32'd20, 1'b1, 1'b1);
    tick();
    chk("t6_c2_shamt", sh_shamt, 32'd8);
    rst = 1'b1;
    #1;
    chk("t6_rst_busy", 32'(busy), 32'd0);
    chk("t6_rst_done", 32'(done), 32'd0);
    chk("t6_rst_out", out, 32'd0);
    tick();
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk("t6_no_done", 32'(done), 32'd0);
      tick();
    end
    chk("t6_out_zero", out, 32'd0);
    req(32'd1234, 32'd4, 1'b0, 1'b0);
    chk("t6_c1_shamt", sh_shamt, 32'd4);
    tick();
    chk("t6_c2_done", 32'(done), 32'd1);
    chk("t6_c2_out", out, 32'd19744);
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/shift_sequencer.md
Name: shift_sequencer

Overview:
- Multi-cycle controller that sequences the combinational 32-bit barrel shifter.
- Each cycle, the shifter receives a shift amount no larger than MAX_STEP, so a long shift is broken into several short ones. This keeps the shifter's critical path short in the KGPminiRISC execute stage.
- The block latches a shift request, drives the shifter once per cycle, accumulates the partial result, and reports completion with a one-cycle done pulse.
- It sits between the ALU control/decode logic and the single shared shifter instance.

Parameters:
- MAX_STEP, 8, largest shift amount issued to the shifter in one cycle; legal range 1..31.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  request strobe; sampled only in IDLE.
- in  input  32  operand to shift.
- shamt  input  32  shift amount; only shamt[4:0] is used, bits 31:5 are ignored.
- dir  input  1  0 = shift left, 1 = shift right.
- arith_or_logic  input  1  1 = arithmetic, 0 = logical; meaningful for right shifts only.
- busy  output  1  high whenever the state is not IDLE.
- done  output  1  one-cycle pulse marking that out holds a new result.
- out  output  32  registered result; holds its value until the next completion.
- sh_in  output  32  operand driven to the shifter (the accumulator).
- sh_shamt  output  32  per-step amount driven to the shifter, zero-extended.
- sh_dir  output  1  latched dir, driven to the shifter.
- sh_arith  output  1  latched arith_or_logic, driven to the shifter.
- sh_out  input  32  combinational result returned by the shifter.

Behaviour:
- Reset:
  - Clock and reset: one clock, clk; reset rst is asynchronous and active-high.
  - Reset forces state=IDLE and clears acc, remaining, latched dir/arith, out and done to 0; busy=0.
- States: IDLE, SHIFT, DONE.
- IDLE:
  - When start=1 at an edge, latch acc<=in, remaining<=shamt[4:0], and the latched dir and arith.
  - Next state is SHIFT if shamt[4:0]!=0, otherwise DONE.
  - start=0 keeps the block in IDLE.
- Step size: step = min(remaining, MAX_STEP). This is combinational from registered state.
- Shifter drive in every state: sh_in=acc, sh_dir and sh_arith from the latched values.
- sh_shamt = {27'b0, step} in SHIFT, and 0 in all other states.
- SHIFT, at each edge:
  - acc<=sh_out and remaining<=remaining-step.
  - If remaining-step==0, go to DONE; otherwise stay in SHIFT.
- DONE:
  - done=1 for exactly this cycle; busy=1.
  - out is loaded with acc on the edge that enters DONE, so it is valid while done=1.
  - On the next edge the block returns to IDLE unconditionally.
- Latency: with n=shamt[4:0] and m=ceil(n/MAX_STEP), SHIFT lasts m cycles and done is high in cycle m+1 after the start-sampling edge.
  - For n=0, m=0 and done is high in cycle 1.
  - No back-to-back acceptance: the earliest next start is sampled in the IDLE cycle after DONE.
- start while busy (SHIFT or DONE) is ignored. No state or operand changes, and no request is queued.
- Chunking is exact for all modes:
  - Logical left/right: zeros are shifted in at every step.
  - Arithmetic right: sign bits are replicated at every step, so the sign is preserved across steps.
  - Arithmetic left: identical to logical left.
- Reset during SHIFT or DONE aborts the operation: done stays 0 and out=0. The next start behaves as from power-up.
- out changes only on entry to DONE or on reset.

Test Plan:
- Short left shift, one step: MAX_STEP=8, start with in=1234, dir=0, logic, shamt=4.
  - sh_shamt=4 for 1 cycle.
  - done high in cycle 2, out=19744; busy high in cycles 1-2.
- Multi-step arithmetic right: in=0x80000000, dir=1, arith=1, shamt=20.
  - sh_shamt sequence 8,8,4.
  - done in cycle 4, out=0xFFFFF800.
- Multi-step logical right: same stimulus as above with arith=0 -> out=0x00000800, same timing.
- Maximum shift: in=1, dir=0, shamt=31 -> steps 8,8,8,7; done in cycle 5; out=0x80000000.
- Zero-amount cases: shamt=0 and shamt=32 (shamt[4:0]=0) with in=0x1234ABCD -> done in cycle 1, out=0x1234ABCD, sh_shamt stays 0.
- Ignored start: while the shamt=20 operation is in SHIFT, pulse start with in=7, shamt=1 -> that start is ignored, out=0xFFFFF800.
- Reset mid-operation: assert rst during the second SHIFT cycle -> done never pulses, out=0. A subsequent start with in=1234, shamt=4 completes with out=19744.
